// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared timer register map, TCON bit indices and helpers
package timer_pkg;

    // Register byte offsets from the peripheral base address
    localparam logic [31:0] TIMER_OFF_TH   = 32'h0000_0000;
    localparam logic [31:0] TIMER_OFF_TL   = 32'h0000_0004;
    localparam logic [31:0] TIMER_OFF_TCON = 32'h0000_0008;

    // TCON bit indices
    localparam int TCON_ENABLE     = 0;
    localparam int TCON_IRQ_ENABLE = 1;
    localparam int TCON_IRQ_STATUS = 2;
    localparam int TCON_ONESHOT    = 3;
    localparam int TCON_WIDTH      = 4;

    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_TH   = 2'd1,
        REG_TL   = 2'd2,
        REG_TCON = 2'd3
    } timer_reg_e;

    // Map a byte address onto a register; anything not exactly on a register is REG_NONE
    function automatic timer_reg_e timer_decode(input logic [31:0] base, input logic [31:0] addr);
        timer_reg_e r;
        r = REG_NONE;
        if (addr == base + TIMER_OFF_TH)   r = REG_TH;
        if (addr == base + TIMER_OFF_TL)   r = REG_TL;
        if (addr == base + TIMER_OFF_TCON) r = REG_TCON;
        return r;
    endfunction

    // CPU write into TCON: status bit can only be cleared by software, never set
    function automatic logic [TCON_WIDTH-1:0] tcon_cpu_merge(input logic [TCON_WIDTH-1:0] cur,
                                                             input logic [31:0] wdata);
        logic [TCON_WIDTH-1:0] n;
        n = wdata[TCON_WIDTH-1:0];
        n[TCON_IRQ_STATUS] = cur[TCON_IRQ_STATUS] & wdata[TCON_IRQ_STATUS];
        return n;
    endfunction

endpackage

// File: rtl/timer_tickgen.sv
// rtl/timer_tickgen.sv - prescaler producing one count tick every PRESCALE enabled cycles
module timer_tickgen
    import timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    logic [15:0] r_count;
    logic        w_last;

    assign w_last = (r_count == 16'(PRESCALE - 1));

    // A clear in the same cycle suppresses the tick so a TL write never sees an increment
    assign o_tick = i_enable & ~i_clear & w_last;

    // Count enabled cycles, wrapping at PRESCALE; hold at zero while disabled or cleared
    always_ff @(posedge clk) begin
        if (reset || !i_enable || i_clear) begin
            r_count <= 16'd0;
        end else if (w_last) begin
            r_count <= 16'd0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule

// File: rtl/timer.sv
// rtl/timer.sv - memory-mapped 32-bit reload timer with one-shot mode and level interrupt
module timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        irq
);

    logic [31:0]           r_th;
    logic [31:0]           r_tl;
    logic [TCON_WIDTH-1:0] r_tcon;

    timer_reg_e            w_sel;
    logic                  w_wr_th;
    logic                  w_wr_tl;
    logic                  w_wr_tcon;
    logic                  w_tick;
    logic                  w_ovf;
    logic [TCON_WIDTH-1:0] w_tcon_next;

    assign w_sel     = timer_decode(BASE_ADDR, Address);
    assign w_wr_th   = MemWrite && (w_sel == REG_TH);
    assign w_wr_tl   = MemWrite && (w_sel == REG_TL);
    assign w_wr_tcon = MemWrite && (w_sel == REG_TCON);

    timer_tickgen #(
        .PRESCALE (PRESCALE)
    ) u_tickgen (
        .clk      (clk),
        .reset    (reset),
        .i_enable (r_tcon[TCON_ENABLE]),
        .i_clear  (w_wr_tl),
        .o_tick   (w_tick)
    );

    assign w_ovf = w_tick && (r_tl == TL_MAX);
    assign irq   = r_tcon[TCON_IRQ_ENABLE] & r_tcon[TCON_IRQ_STATUS];

    // Next TCON: CPU write first, then overflow status set and one-shot stop override it
    always_comb begin
        w_tcon_next = r_tcon;
        if (w_wr_tcon) begin
            w_tcon_next = tcon_cpu_merge(r_tcon, Write_data);
        end
        if (w_ovf) begin
            if (w_tcon_next[TCON_IRQ_ENABLE]) begin
                w_tcon_next[TCON_IRQ_STATUS] = 1'b1;
            end
            if (w_tcon_next[TCON_ONESHOT]) begin
                w_tcon_next[TCON_ENABLE] = 1'b0;
            end
        end
    end

    // Reload register: plain CPU write; overflow in the same cycle still uses the old value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_th <= 32'h0;
        end else if (w_wr_th) begin
            r_th <= Write_data;
        end
    end

    // Counter: CPU write beats a tick; overflow reloads from TH instead of wrapping to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tl <= 32'h0;
        end else if (w_wr_tl) begin
            r_tl <= Write_data;
        end else if (w_tick) begin
            r_tl <= w_ovf ? r_th : (r_tl + 32'd1);
        end
    end

    // Control/status register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcon <= '0;
        end else begin
            r_tcon <= w_tcon_next;
        end
    end

    // Read mux: zero for idle bus, unmapped and unaligned addresses
    always_comb begin
        Read_data = 32'h0;
        if (MemRead) begin
            case (w_sel)
                REG_TH:   Read_data = r_th;
                REG_TL:   Read_data = r_tl;
                REG_TCON: Read_data = {{(32-TCON_WIDTH){1'b0}}, r_tcon};
                default:  Read_data = 32'h0;
            endcase
        end
    end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: Timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h4000_0000: byte address of TH; TL at +4, TCON at +8.
REQ-002 Parameter PRESCALE, default 1: clk cycles per count tick, legal range 1..65535.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 MemRead  input  1  bus read strobe, already qualified by the bus decoder for this slave.
REQ-006 MemWrite  input  1  bus write strobe, already qualified by the bus decoder for this slave.
REQ-007 Address  input  32  byte address of the access.
REQ-008 Write_data  input  32  write data.
REQ-009 Read_data  output  32  read data, combinational from Address/MemRead and current register state.
REQ-010 irq  output  1  interrupt request, level, = TCON[1] & TCON[2].

Function
REQ-011 Registers: TH[31:0] reload value; TL[31:0] counter; TCON[3:0] = {oneshot, irq_status, irq_enable, enable}; TCON[31:4] read as 0.
REQ-012 Read_data = selected register when MemRead and Address equals BASE_ADDR, +4 or +8; 32'h0 otherwise, including unmapped or unaligned addresses.
REQ-013 Writes take effect at the rising edge where MemWrite is high and Address matches; writes to unmapped addresses are ignored.
REQ-014 Prescaler: a 16-bit counter runs only while TCON[0]=1; it emits a one-cycle tick every PRESCALE cycles and clears whenever TCON[0]=0 or on any write to TL.
REQ-015 On each tick, TL increments by 1, except when TL=32'hFFFF_FFFF (overflow): TL loads TH instead.
REQ-016 Overflow sets TCON[2] when TCON[1]=1; when TCON[3]=1, overflow also clears TCON[0], and TL still reloads TH.
REQ-017 Counting latency: with PRESCALE=1, TL changes on the first edge after the edge that sets TCON[0].
REQ-018 The CPU clears TCON[2] by writing 0 to bit 2; writing 1 to bit 2 has no effect (write-0-to-clear).
REQ-019 Simultaneous CPU TL write and tick: the CPU value wins, with no increment that cycle.
REQ-020 Simultaneous CPU TCON write and overflow: CPU bits [3:0] apply first; the overflow set of bit 2 and the one-shot clear of bit 0 then override.
REQ-021 Simultaneous CPU TH write and overflow: TL reloads the old TH; TH takes the new value.
REQ-022 irq stays asserted until software clears TCON[2] or clears TCON[1].

Reset
REQ-023 On reset, TH=0, TL=0, TCON=0 and the prescaler is 0; irq=0 on the cycle after reset is sampled.
REQ-024 Reset overrides any concurrent bus write or tick.
REQ-025 Read_data stays combinational during reset and reflects the register values.

Structure
REQ-026 The register offsets (0, 4, 8) and TCON bit indices live in the shared peripheral constants package used by the bus decoder and the software headers.
REQ-027 The prescaler is one sub-module, TickGen: PRESCALE parameter, enable/clear inputs, tick output.
REQ-028 The register file and overflow logic stay in Timer; there is no other hierarchy.
REQ-029 Timer contains no latches and no asynchronous logic other than the Read_data mux and irq.

Verification
REQ-030 Reset, then read +0, +4, +8 -> all 32'h0; irq=0.
REQ-031 PRESCALE=1; write TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=4'b0011 -> TL=32'hFFFF_FFFF after 1 tick, 32'hFFFF_FFF0 after 2; irq=1 from that edge onward.
REQ-032 With irq=1, write TCON=4'b0011 (bit 2=0) -> irq=0 next cycle; counting continues from the reloaded value.
REQ-033 PRESCALE=4; TL=0, TCON=4'b0001 -> TL=1 after 4 cycles and 2 after 8.
REQ-034 One-shot: TH=5, TL=32'hFFFF_FFFF, TCON=4'b1011 -> on overflow TL=5, TCON=4'b1110, TL holds 5 thereafter.
REQ-035 Collision: TCON write of 4'b0011 on the same edge as overflow -> TCON[2]=1. TL write of 32'h1234 on the same edge as a tick -> TL=32'h1234. Read of BASE_ADDR+12 -> 32'h0.
